cm0_dap_cdc_addr_capture: RTL and testbench

CM0_DAP_CDC_ADDR_CAPTURE -- requirements
Module: cm0_dap_cdc_addr_capture

---
 rtl/cm0_dap_cdc_addr_capture.sv | 114 +++++++++++
 tb/tb_cm0_dap_cdc_addr_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cm0_dap_cdc_addr_capture.sv
// Receiving-domain side of a 4-phase request/acknowledge address crossing.
// CM0_DAP_CDC_SYNC3_EN selects a 3-stage request synchroniser instead of the default 2 stages.
//
// state | meaning
// IDLE  | waiting for synchronised request; all outputs low
// OPEN  | MASKEN raised for one cycle so the upstream mask output settles
// CAPT  | address captured and offered to the consumer, mask held open
// ACKH  | acknowledge raised; waiting for the request to drop
module cm0_dap_cdc_addr_capture #(
   parameter int PRESENT = 1
) (
   input  logic       DCLK,
   input  logic       DRESET,
   input  logic       REQ_ASYNC,
   input  logic [3:0] ADDR_MASKED,
   output logic       MASKEN,
   output logic       ACK,
   output logic [3:0] ADDR_Q,
   output logic       ADDR_VALID,
   input  logic       ADDR_READY
);

`ifdef CM0_DAP_CDC_SYNC3_EN
   localparam int SYNC_STAGES = 3;
`else
   localparam int SYNC_STAGES = 2;
`endif

   generate
      if (PRESENT != 0) begin : g_present
         typedef enum logic [1:0] {
            IDLE = 2'd0,
            OPEN = 2'd1,
            CAPT = 2'd2,
            ACKH = 2'd3
         } state_t;

         state_t                 state_q;
         logic [SYNC_STAGES-1:0] sync_q;
         logic                   req_sync;
         logic                   masken_q;
         logic                   ack_q;
         logic                   valid_q;
         logic [3:0]             addr_q;

         // REQ_ASYNC is sampled only by the first stage of this chain.
         always_ff @(posedge DCLK) begin
            if (DRESET) begin
               sync_q <= '0;
            end else begin
               sync_q <= {sync_q[SYNC_STAGES-2:0], REQ_ASYNC};
            end
         end

         assign req_sync = sync_q[SYNC_STAGES-1];

         // Outputs are loaded alongside the state so each one is a plain flop.
         always_ff @(posedge DCLK) begin
            if (DRESET) begin
               state_q  <= IDLE;
               masken_q <= 1'b0;
               ack_q    <= 1'b0;
               valid_q  <= 1'b0;
               addr_q   <= 4'h0;
            end else begin
               case (state_q)
                  IDLE: begin
                     if (req_sync) begin
                        state_q  <= OPEN;
                        masken_q <= 1'b1;
                     end
                  end
                  OPEN: begin
                     state_q <= CAPT;
                     valid_q <= 1'b1;
                     addr_q  <= ADDR_MASKED;
                  end
                  CAPT: begin
                     if (valid_q && ADDR_READY) begin
                        state_q  <= ACKH;
                        masken_q <= 1'b0;
                        valid_q  <= 1'b0;
                        ack_q    <= 1'b1;
                     end
                  end
                  ACKH: begin
                     if (!req_sync) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                     end
                  end
                  default: begin
                     state_q  <= IDLE;
                     masken_q <= 1'b0;
                     ack_q    <= 1'b0;
                     valid_q  <= 1'b0;
                  end
               endcase
            end
         end

         assign MASKEN     = masken_q;
         assign ACK        = ack_q;
         assign ADDR_VALID = valid_q;
         assign ADDR_Q     = addr_q;
      end else begin : g_absent
         assign MASKEN     = 1'b0;
         assign ACK        = 1'b0;
         assign ADDR_VALID = 1'b0;
         assign ADDR_Q     = 4'h0;
      end
   endgenerate

endmodule

// File: tb/tb_cm0_dap_cdc_addr_capture.sv
// Directed bench for cm0_dap_cdc_addr_capture: a vector table for the basic
// handshake plus hand-written sequences for backpressure, masking, reset and held requests.
module tb_cm0_dap_cdc_addr_capture;

`ifdef CM0_DAP_CDC_SYNC3_EN
   localparam int S = 3;
`else
   localparam int S = 2;
`endif

   logic       DCLK = 1'b0;
   logic       DRESET;
   logic       REQ_ASYNC;
   logic [3:0] ADDR_MASKED;
   logic       MASKEN;
   logic       ACK;
   logic [3:0] ADDR_Q;
   logic       ADDR_VALID;
   logic       ADDR_READY;

   int n_checks = 0;
   int n_fail   = 0;

   cm0_dap_cdc_addr_capture #(.PRESENT(1)) dut (
      .DCLK        (DCLK),
      .DRESET      (DRESET),
      .REQ_ASYNC   (REQ_ASYNC),
      .ADDR_MASKED (ADDR_MASKED),
      .MASKEN      (MASKEN),
      .ACK         (ACK),
      .ADDR_Q      (ADDR_Q),
      .ADDR_VALID  (ADDR_VALID),
      .ADDR_READY  (ADDR_READY)
   );

   always #5 DCLK = ~DCLK;

   typedef struct {
      logic       req;
      logic [3:0] addr;
      logic       ready;
      logic       e_masken;
      logic       e_ack;
      logic       e_valid;
      logic [3:0] e_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock edge, then settle; MASKEN and ACK must never be high together.
   task automatic step();
      @(posedge DCLK);
      #1;
      check("masken_ack_exclusive", int'(MASKEN & ACK), 0);
   endtask

   task automatic add_vec(input logic req, input logic [3:0] addr, input logic ready,
                          input logic em, input logic ea, input logic ev, input logic [3:0] eq);
      vec_t v;
      v.req = req; v.addr = addr; v.ready = ready;
      v.e_masken = em; v.e_ack = ea; v.e_valid = ev; v.e_addr = eq;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      DRESET = 1'b1;
      step();
      step();
      DRESET = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 0;
      while ((ACK || MASKEN || ADDR_VALID) && k < 30) begin
         step();
         k++;
      end
      check({name, "_idle_timeout"}, int'(k < 30), 1);
   endtask

   initial begin
      int  cnt;
      int  ack_len;
      logic seen_valid;

      DRESET      = 1'b1;
      REQ_ASYNC   = 1'b0;
      ADDR_MASKED = 4'h0;
      ADDR_READY  = 1'b1;
      #1;
      step();
      step();
      check("reset_masken", int'(MASKEN), 0);
      check("reset_ack",    int'(ACK), 0);
      check("reset_valid",  int'(ADDR_VALID), 0);
      check("reset_addr",   int'(ADDR_Q), 0);
      DRESET = 1'b0;
      step();
      check("idle_no_req_masken", int'(MASKEN), 0);

      // Basic handshake: each row is inputs before an edge and outputs after it.
      for (int i = 0; i < S; i++) add_vec(1, 4'hA, 1, 0, 0, 0, 4'h0);
      add_vec(1, 4'hA, 1, 1, 0, 0, 4'h0);   // OPEN
      add_vec(1, 4'hA, 1, 1, 0, 1, 4'hA);   // CAPT, ADDR_VALID at edge S+2
      add_vec(1, 4'hA, 1, 0, 1, 0, 4'hA);   // ACKH
      add_vec(1, 4'h6, 1, 0, 1, 0, 4'hA);
      for (int i = 0; i < S; i++) add_vec(0, 4'h6, 1, 0, 1, 0, 4'hA);
      add_vec(0, 4'h6, 1, 0, 0, 0, 4'hA);   // back to IDLE
      add_vec(0, 4'h6, 1, 0, 0, 0, 4'hA);

      foreach (vecs[i]) begin
         REQ_ASYNC   = vecs[i].req;
         ADDR_MASKED = vecs[i].addr;
         ADDR_READY  = vecs[i].ready;
         step();
         check($sformatf("vec%0d_masken", i), int'(MASKEN),     int'(vecs[i].e_masken));
         check($sformatf("vec%0d_ack", i),    int'(ACK),        int'(vecs[i].e_ack));
         check($sformatf("vec%0d_valid", i),  int'(ADDR_VALID), int'(vecs[i].e_valid));
         check($sformatf("vec%0d_addr", i),   int'(ADDR_Q),     int'(vecs[i].e_addr));
      end

      // Backpressure: consumer stalls, address and valid must hold.
      do_reset();
      ADDR_READY  = 1'b0;
      ADDR_MASKED = 4'h5;
      REQ_ASYNC   = 1'b1;
      for (int i = 0; i < S + 2; i++) step();
      check("bp_valid_rise", int'(ADDR_VALID), 1);
      for (int i = 0; i < 6; i++) begin
         ADDR_MASKED = 4'(i + 8);
         step();
         check("bp_valid_held", int'(ADDR_VALID), 1);
         check("bp_addr_stable", int'(ADDR_Q), 5);
         check("bp_ack_low", int'(ACK), 0);
         check("bp_masken_high", int'(MASKEN), 1);
      end
      ADDR_READY = 1'b1;
      step();
      check("bp_valid_drop", int'(ADDR_VALID), 0);
      check("bp_ack_high", int'(ACK), 1);
      check("bp_addr_kept", int'(ADDR_Q), 5);
      REQ_ASYNC = 1'b0;
      wait_idle("bp");

      // Mask isolation: only the value present at the OPEN->CAPT edge is captured.
      do_reset();
      ADDR_MASKED = 4'h3;
      REQ_ASYNC   = 1'b1;
      for (int i = 0; i < S + 1; i++) step();
      check("mask_open_masken", int'(MASKEN), 1);
      check("mask_open_valid", int'(ADDR_VALID), 0);
      ADDR_MASKED = 4'hC;
      step();
      check("mask_capt_addr", int'(ADDR_Q), 12);
      ADDR_MASKED = 4'hF;
      step();
      check("mask_ackh_addr", int'(ADDR_Q), 12);
      check("mask_ackh_ack", int'(ACK), 1);
      REQ_ASYNC = 1'b0;
      wait_idle("mask");

      // Reset in CAPT aborts; a still-high request restarts afterwards.
      do_reset();
      ADDR_READY  = 1'b0;
      ADDR_MASKED = 4'h9;
      REQ_ASYNC   = 1'b1;
      for (int i = 0; i < S + 2; i++) step();
      check("rst_mid_in_capt", int'(ADDR_VALID), 1);
      DRESET = 1'b1;
      step();
      check("rst_mid_masken", int'(MASKEN), 0);
      check("rst_mid_ack", int'(ACK), 0);
      check("rst_mid_valid", int'(ADDR_VALID), 0);
      check("rst_mid_addr", int'(ADDR_Q), 0);
      DRESET      = 1'b0;
      ADDR_MASKED = 4'h7;
      for (int i = 0; i < S + 1; i++) begin
         step();
         check("restart_no_early_valid", int'(ADDR_VALID), 0);
      end
      step();
      check("restart_valid", int'(ADDR_VALID), 1);
      check("restart_addr", int'(ADDR_Q), 7);

      // Held request: one handshake only while REQ_ASYNC stays high.
      ADDR_READY = 1'b1;
      step();
      check("held_ack", int'(ACK), 1);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (ADDR_VALID) cnt++;
         if (i == 19) check("held_ack_still", int'(ACK), 1);
      end
      check("held_extra_valids", cnt, 0);
      REQ_ASYNC = 1'b0;
      wait_idle("held");

      // Request withdrawn during OPEN: transfer completes, ACKH leaves promptly.
      do_reset();
      ADDR_MASKED = 4'hB;
      REQ_ASYNC   = 1'b1;
      for (int i = 0; i < S + 1; i++) step();
      check("viol_open", int'(MASKEN), 1);
      REQ_ASYNC  = 1'b0;
      seen_valid = 1'b0;
      cnt = 0;
      while (!ACK && cnt < 20) begin
         step();
         if (ADDR_VALID) seen_valid = 1'b1;
         cnt++;
      end
      check("viol_ack_timeout", int'(cnt < 20), 1);
      check("viol_valid_seen", int'(seen_valid), 1);
      check("viol_addr", int'(ADDR_Q), 11);
      ack_len = 0;
      while (ACK && ack_len < 20) begin
         step();
         ack_len++;
      end
      check("viol_ack_len", ack_len, S - 1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (ADDR_VALID || MASKEN) cnt++;
      end
      check("viol_no_restart", cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
